// File: rtl/cotm32_pkg.sv
// Shared widths and immediate-format encoding for the cotm32 core.
package cotm32_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // Immediate format select; codes 5..7 are unused and treated as invalid.
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_t;

endpackage

// File: rtl/imm_inst_gen_if.sv
// Request and instruction-stream handshake bundle for imm_inst_gen.
interface imm_inst_gen_if;
    import cotm32_pkg::*;

    logic                    i_req_valid;
    logic                    o_req_ready;
    logic                    i_req_li;
    imm_t                    i_req_fmt;
    logic [XLEN-1:0]         i_req_base;
    logic [XLEN-1:0]         i_req_imm;
    logic [REG_ADDR_W-1:0]   i_req_rd;
    logic                    o_inst_valid;
    logic                    i_inst_ready;
    logic [INST_WIDTH-1:0]   o_inst;
    logic                    o_inst_last;
    logic                    o_inst_err;

    // Requester / consumer side.
    modport master (
        output i_req_valid, i_req_li, i_req_fmt, i_req_base, i_req_imm, i_req_rd,
        output i_inst_ready,
        input  o_req_ready, o_inst_valid, o_inst, o_inst_last, o_inst_err
    );

    // Generator side.
    modport slave (
        input  i_req_valid, i_req_li, i_req_fmt, i_req_base, i_req_imm, i_req_rd,
        input  i_inst_ready,
        output o_req_ready, o_inst_valid, o_inst, o_inst_last, o_inst_err
    );

endinterface

// File: rtl/imm_inst_gen.sv
// Immediate instruction generator: splices immediates into RV32 templates (ENC)
// or expands `li rd, imm` into LUI/ADDI, emitted over a registered valid/ready stream.
module imm_inst_gen
    import cotm32_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    imm_inst_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OUT_ONE = 2'd1,
        ST_OUT_HI  = 2'd2,
        ST_OUT_LO  = 2'd3
    } state_t;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    state_t                state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  last_q,  last_d;
    logic                  err_q,   err_d;
    logic [INST_WIDTH-1:0] inst_q,  inst_d;
    logic [INST_WIDTH-1:0] lo_q,    lo_d;

    logic                  accept;
    logic                  consume;
    logic                  fit11, fit12, fit20;
    logic [INST_WIDTH-1:0] enc_inst;
    logic                  enc_err;
    logic [11:0]           li_lo;
    logic [19:0]           li_hi;
    logic [REG_ADDR_W-1:0] rd;

    assign bus.o_req_ready  = !valid_q || (bus.i_inst_ready && last_q);
    assign bus.o_inst_valid = valid_q;
    assign bus.o_inst       = inst_q;
    assign bus.o_inst_last  = last_q;
    assign bus.o_inst_err   = err_q;

    assign accept  = bus.i_req_valid && bus.o_req_ready;
    assign consume = valid_q && bus.i_inst_ready;

    // Sign-extension range checks: upper bits all copies of the top kept bit.
    assign fit11 = (&bus.i_req_imm[31:11]) || !(|bus.i_req_imm[31:11]);
    assign fit12 = (&bus.i_req_imm[31:12]) || !(|bus.i_req_imm[31:12]);
    assign fit20 = (&bus.i_req_imm[31:20]) || !(|bus.i_req_imm[31:20]);

    assign rd    = bus.i_req_rd;
    assign li_lo = bus.i_req_imm[11:0];
    assign li_hi = bus.i_req_imm[31:12] + 20'(bus.i_req_imm[11]);

    // ENC: overwrite only the immediate fields of the template.
    always_comb begin
        enc_inst = bus.i_req_base;
        enc_err  = 1'b0;
        case (bus.i_req_fmt)
            IMM_I: begin
                enc_inst[31:20] = bus.i_req_imm[11:0];
                enc_err         = !fit11;
            end
            IMM_S: begin
                enc_inst[31:25] = bus.i_req_imm[11:5];
                enc_inst[11:7]  = bus.i_req_imm[4:0];
                enc_err         = !fit11;
            end
            IMM_B: begin
                enc_inst[31]    = bus.i_req_imm[12];
                enc_inst[30:25] = bus.i_req_imm[10:5];
                enc_inst[11:8]  = bus.i_req_imm[4:1];
                enc_inst[7]     = bus.i_req_imm[11];
                enc_err         = bus.i_req_imm[0] || !fit12;
            end
            IMM_U: begin
                enc_inst[31:12] = bus.i_req_imm[31:12];
                enc_err         = |bus.i_req_imm[11:0];
            end
            IMM_J: begin
                enc_inst[31]    = bus.i_req_imm[20];
                enc_inst[30:21] = bus.i_req_imm[10:1];
                enc_inst[20]    = bus.i_req_imm[11];
                enc_inst[19:12] = bus.i_req_imm[19:12];
                enc_err         = bus.i_req_imm[0] || !fit20;
            end
            default: begin
                enc_inst = bus.i_req_base;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Next-state and output-register logic; a stall holds everything.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = err_q;
        inst_d  = inst_q;
        lo_d    = lo_q;
        if (accept) begin
            valid_d = 1'b1;
            state_d = ST_OUT_ONE;
            last_d  = 1'b1;
            err_d   = 1'b0;
            if (bus.i_req_li) begin
                if (fit11) begin
                    inst_d = {li_lo, 5'd0, 3'b000, rd, OP_IMM};
                end else if (li_lo == 12'd0) begin
                    inst_d = {li_hi, rd, OP_LUI};
                end else begin
                    inst_d  = {li_hi, rd, OP_LUI};
                    lo_d    = {li_lo, rd, 3'b000, rd, OP_IMM};
                    last_d  = 1'b0;
                    state_d = ST_OUT_HI;
                end
            end else begin
                inst_d = enc_inst;
                err_d  = enc_err;
            end
        end else if (consume) begin
            if (state_q == ST_OUT_HI) begin
                inst_d  = lo_q;
                last_d  = 1'b1;
                err_d   = 1'b0;
                state_d = ST_OUT_LO;
            end else begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            inst_q  <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
            inst_q  <= inst_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_imm_inst_gen.sv
// Directed self-checking bench for imm_inst_gen.
module tb_imm_inst_gen;
    import cotm32_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    imm_inst_gen_if bus();

    imm_inst_gen dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic li, input logic [2:0] fmt, input logic [31:0] base,
                             input logic [31:0] imm, input logic [4:0] rd);
        bus.i_req_valid = 1'b1;
        bus.i_req_li    = li;
        bus.i_req_fmt   = imm_t'(fmt);
        bus.i_req_base  = base;
        bus.i_req_imm   = imm;
        bus.i_req_rd    = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_tests++;
        if (bus.o_inst_valid !== 1'b0 || bus.o_inst !== 32'h0 || bus.o_inst_last !== 1'b0 ||
            bus.o_inst_err !== 1'b0 || bus.o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: valid=%b inst=%h last=%b err=%b ready=%b, want 0 00000000 0 0 1",
                     bus.o_inst_valid, bus.o_inst, bus.o_inst_last, bus.o_inst_err, bus.o_req_ready);
        end
    endtask

    task automatic test_li();
        logic [31:0] imm_tab [4] = '{32'h12345678, 32'h00000800, 32'hFFFFFFFF, 32'hABCDE000};
        logic [4:0]  rd_tab  [4] = '{5'd5, 5'd10, 5'd1, 5'd2};
        logic [31:0] b0_tab  [4] = '{32'h123452B7, 32'h00001537, 32'hFFF00093, 32'hABCDE137};
        logic [31:0] b1_tab  [4] = '{32'h67828293, 32'h80050513, 32'h0, 32'h0};
        logic        two_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bus.i_inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 3'd0, 32'h0, imm_tab[i], rd_tab[i]);
            step();
            bus.i_req_valid = 1'b0;
            n_tests++;
            if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== b0_tab[i] ||
                bus.o_inst_last !== !two_tab[i] || bus.o_inst_err !== 1'b0) begin
                n_fail++;
                $display("FAIL li%0d_first: valid=%b inst=%h last=%b err=%b, want 1 %h %b 0",
                         i, bus.o_inst_valid, bus.o_inst, bus.o_inst_last, bus.o_inst_err,
                         b0_tab[i], !two_tab[i]);
            end
            if (two_tab[i]) begin
                step();
                n_tests++;
                if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== b1_tab[i] ||
                    bus.o_inst_last !== 1'b1 || bus.o_inst_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL li%0d_second: valid=%b inst=%h last=%b err=%b, want 1 %h 1 0",
                             i, bus.o_inst_valid, bus.o_inst, bus.o_inst_last, bus.o_inst_err,
                             b1_tab[i]);
                end
            end
            step();
            n_tests++;
            if (bus.o_inst_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL li%0d_drain: valid=%b ready=%b, want 0 1",
                         i, bus.o_inst_valid, bus.o_req_ready);
            end
        end
    endtask

    task automatic test_enc();
        logic [2:0]  fmt_tab  [10] = '{3'd2, 3'd2, 3'd3, 3'd0, 3'd0, 3'd1, 3'd4, 3'd4, 3'd7, 3'd3};
        logic [31:0] base_tab [10] = '{32'h00000063, 32'h00000063, 32'h00000037, 32'h00000013,
                                       32'h00000013, 32'h00002023, 32'h0000006F, 32'h0000006F,
                                       32'hDEADBEEF, 32'h12345037};
        logic [31:0] imm_tab  [10] = '{32'hFFFFFFFC, 32'h00000003, 32'h00000001, 32'hFFFFF800,
                                       32'h00000800, 32'h000007FF, 32'h00000800, 32'h00100000,
                                       32'h00000000, 32'hABCDE000};
        logic [31:0] exp_tab  [10] = '{32'hFE000EE3, 32'h00000163, 32'h00000037, 32'h80000013,
                                       32'h80000013, 32'h7E002FA3, 32'h0010006F, 32'h8000006F,
                                       32'hDEADBEEF, 32'hABCDE037};
        logic        err_tab  [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        bus.i_inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_req(1'b0, fmt_tab[i], base_tab[i], imm_tab[i], 5'd31);
            step();
            bus.i_req_valid = 1'b0;
            n_tests++;
            if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== exp_tab[i] ||
                bus.o_inst_err !== err_tab[i] || bus.o_inst_last !== 1'b1) begin
                n_fail++;
                $display("FAIL enc%0d: valid=%b inst=%h err=%b last=%b, want 1 %h %b 1",
                         i, bus.o_inst_valid, bus.o_inst, bus.o_inst_err, bus.o_inst_last,
                         exp_tab[i], err_tab[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        bus.i_inst_ready = 1'b0;
        drive_req(1'b1, 3'd0, 32'h0, 32'h12345678, 5'd5);
        step();
        // A competing request stays offered during the stall and must not be taken.
        drive_req(1'b0, 3'd0, 32'h00000013, 32'h00000001, 5'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== 32'h123452B7 ||
                bus.o_inst_last !== 1'b0 || bus.o_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall%0d: valid=%b inst=%h last=%b ready=%b, want 1 123452b7 0 0",
                         c, bus.o_inst_valid, bus.o_inst, bus.o_inst_last, bus.o_req_ready);
            end
        end
        bus.i_req_valid  = 1'b0;
        bus.i_inst_ready = 1'b1;
        step();
        n_tests++;
        if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== 32'h67828293 || bus.o_inst_last !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b inst=%h last=%b, want 1 67828293 1",
                     bus.o_inst_valid, bus.o_inst, bus.o_inst_last);
        end
        step();
        n_tests++;
        if (bus.o_inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_drain: valid=%b, want 0", bus.o_inst_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_tab [3] = '{32'h00100013, 32'h00200013, 32'h00300013};
        bus.i_inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b0, 3'd0, 32'h00000013, 32'(i + 1), 5'd0);
            step();
            n_tests++;
            if (bus.o_inst_valid !== 1'b1 || bus.o_inst !== exp_tab[i] || bus.o_req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b%0d: valid=%b inst=%h ready=%b, want 1 %h 1",
                         i, bus.o_inst_valid, bus.o_inst, bus.o_req_ready, exp_tab[i]);
            end
        end
        bus.i_req_valid = 1'b0;
        step();
        n_tests++;
        if (bus.o_inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: valid=%b, want 0", bus.o_inst_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.i_inst_ready = 1'b0;
        drive_req(1'b1, 3'd0, 32'h0, 32'h12345678, 5'd5);
        step();
        bus.i_req_valid = 1'b0;
        n_tests++;
        if (bus.o_inst !== 32'h123452B7 || bus.o_inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_hi: valid=%b inst=%h, want 1 123452b7",
                     bus.o_inst_valid, bus.o_inst);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (bus.o_inst_valid !== 1'b0 || bus.o_inst !== 32'h0 || bus.o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_after: valid=%b inst=%h ready=%b, want 0 00000000 1",
                     bus.o_inst_valid, bus.o_inst, bus.o_req_ready);
        end
        bus.i_inst_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (bus.o_inst_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_nolo%0d: valid=%b inst=%h, want valid 0",
                         c, bus.o_inst_valid, bus.o_inst);
            end
        end
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        rst              = 1'b0;
        bus.i_req_valid  = 1'b0;
        bus.i_req_li     = 1'b0;
        bus.i_req_fmt    = IMM_I;
        bus.i_req_base   = 32'h0;
        bus.i_req_imm    = 32'h0;
        bus.i_req_rd     = 5'd0;
        bus.i_inst_ready = 1'b0;
        #1;
        test_reset();
        test_li();
        test_enc();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
